// File: rtl/fetch_stage.sv
// Purpose: instruction-fetch stage; PC register driving a zero-latency imem, IF/ID output register to decode.
// Latency: the instruction at pc is on id_* one cycle after the load; a redirect target reaches id_* two cycles after redirect_valid.
// Backpressure: id_valid && !id_ready holds id_instr/id_pc and freezes pc; a redirect flushes id_* even under backpressure.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   fetch_en                     run enable; low stops new fetches, the held id_* entry is still handed over
//   imem_addr / imem_instr       byte address out (equals pc), instruction word back in the same cycle
//   redirect_valid / redirect_pc branch/jump redirect from execute; highest priority
//   id_valid / id_ready          valid/ready handshake to decode carrying id_instr and id_pc
//   fetch_count                  completed decode handshakes, wraps at 2^32
//   fetch_fault                  sticky misaligned-redirect flag
//
// Optional feature macro: ALIGN_CHECK_EN
//   defined   : a misaligned redirect sets fetch_fault and parks the stage in FAULT until reset
//   undefined : redirect_pc[1:0] is forced to 2'b00, fetch_fault is tied 0, no FAULT state
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

`ifdef ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  ifid_t       ifid;
  logic        load;
  logic        xfer;
  logic        redir_take;
  logic [31:0] redir_target;

  assign imem_addr = pc;
  assign id_instr  = ifid.instr;
  assign id_pc     = ifid.pc;
  assign xfer      = id_valid && id_ready;

`ifdef ALIGN_CHECK_EN
  logic redir_bad;
  // Once faulted every further redirect is ignored.
  assign redir_take   = redirect_valid && (state != FAULT);
  assign redir_bad    = redir_take && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_take   = redirect_valid;
  assign redir_target = {redirect_pc[31:2], 2'b00};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and load decision. A redirect in the same cycle suppresses the
  // load so that the first fetch from the target happens on the next cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en) state_nxt = RUN;
      end
      RUN: begin
        load = (!id_valid || id_ready) && !redirect_valid;
        if (!fetch_en) state_nxt = IDLE;
      end
`ifdef ALIGN_CHECK_EN
      FAULT: begin
        state_nxt = FAULT;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef ALIGN_CHECK_EN
    if (redir_bad) state_nxt = FAULT;
`endif
  end

  // PC, IF/ID register and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      ifid        <= '{instr: NOP_INSTR, pc: RESET_PC};
      fetch_count <= '0;
    end else begin
      // A transfer coinciding with a redirect still completed, so it counts.
      if (xfer) fetch_count <= fetch_count + 32'd1;

      if (redir_take) begin
        pc       <= redir_target;
        id_valid <= 1'b0;
      end else if (load) begin
        ifid     <= '{instr: imem_instr, pc: pc};
        id_valid <= 1'b1;
        pc       <= pc + 32'(PC_STEP);
      end else if (xfer) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_fault <= 1'b0;
    end else if (redir_bad) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: self-checking bench for fetch_stage: directed scenarios with literal expectations plus randomized traffic.
// Latency: the reference model advances once per rising edge; outputs are compared on every falling edge.
// Backpressure: id_ready, fetch_en and redirects are randomized, so hold/flush behaviour is exercised continuously.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] fetch_count;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_count    (fetch_count),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory, aliased every 256 bytes.
  function automatic logic [31:0] mem_at(logic [31:0] addr);
    return mem[(addr / 4) % 64];
  endfunction

  assign imem_instr = mem_at(imem_addr);

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] cnt;
    logic        running;
    logic        faulted;
    logic        vld;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.pc      = 32'h0;
    r.instr   = 32'h0000_0013;
    r.ipc     = 32'h0;
    r.cnt     = 32'h0;
    r.running = 1'b0;
    r.faulted = 1'b0;
    r.vld     = 1'b0;
    return r;
  endfunction

  // One clock of the fetch rules: handshake counting, redirect priority,
  // then fetch when the output slot is free or draining.
  function automatic mdl_t mdl_step(mdl_t s, logic en, logic rdy, logic rv, logic [31:0] rpc);
    mdl_t n;
    n = s;
    if (s.vld && rdy) n.cnt = s.cnt + 32'd1;
    if (s.faulted) return n;
    n.running = en;
    if (rv) begin
      n.vld = 1'b0;
`ifdef ALIGN_CHECK_EN
      n.pc = rpc;
      if (rpc % 4 != 0) n.faulted = 1'b1;
`else
      n.pc = rpc - (rpc % 4);
`endif
    end else if (s.running && (!s.vld || rdy)) begin
      n.vld   = 1'b1;
      n.ipc   = s.pc;
      n.instr = mem_at(s.pc);
      n.pc    = s.pc + 32'd4;
    end else if (s.vld && rdy) begin
      n.vld = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= mdl_step(m, fetch_en, id_ready, redirect_valid, redirect_pc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("mdl.id_valid",    {31'd0, id_valid},    {31'd0, m.vld});
      check("mdl.id_pc",       id_pc,                m.ipc);
      check("mdl.id_instr",    id_instr,             m.instr);
      check("mdl.imem_addr",   imem_addr,            m.pc);
      check("mdl.fetch_count", fetch_count,          m.cnt);
      check("mdl.fetch_fault", {31'd0, fetch_fault}, {31'd0, m.faulted});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    repeat (3) tick();
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    check("rst.id_valid",    {31'd0, id_valid}, 32'd0);
    check("rst.id_instr",    id_instr,          32'h0000_0013);
    check("rst.id_pc",       id_pc,             32'h0);
    check("rst.imem_addr",   imem_addr,         32'h0);
    check("rst.fetch_count", fetch_count,       32'h0);
    check("rst.fetch_fault", {31'd0, fetch_fault}, 32'd0);

    // Streaming: first edge enters run, then one instruction per cycle.
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check("seq.id_pc",    id_pc,    32'(4 * k));
      check("seq.id_instr", id_instr, mem[k]);
      if (k < 2) tick();
    end

    // Backpressure while id_pc=8.
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp.id_valid",  {31'd0, id_valid}, 32'd1);
      check("bp.id_pc",     id_pc,             32'h8);
      check("bp.id_instr",  id_instr,          mem[2]);
      check("bp.imem_addr", imem_addr,         32'hC);
    end
    id_ready = 1'b1;
    tick();
    check("bp.resume_pc", id_pc, 32'hC);
    tick();
    check("seq.pc16", id_pc, 32'h10);
    tick();
    check("seq.count5", fetch_count, 32'd5);

    // Redirect while stalled.
    id_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    check("redir.flush",     {31'd0, id_valid}, 32'd0);
    check("redir.imem_addr", imem_addr,         32'h40);
    tick();
    check("redir.id_pc",    id_pc,    32'h40);
    check("redir.id_instr", id_instr, mem[16]);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap.imem_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap.id_pc",     id_pc,     32'hFFFF_FFFC);
    check("wrap.imem_addr", imem_addr, 32'h0);
    tick();

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
    check("mis.fault",     {31'd0, fetch_fault}, 32'd1);
    check("mis.imem_addr", imem_addr,            32'h42);
    for (int k = 0; k < 5; k++) begin
      redirect_valid = (k == 1);
      redirect_pc    = 32'h100;
      tick();
      check("mis.id_valid", {31'd0, id_valid},    32'd0);
      check("mis.sticky",   {31'd0, fetch_fault}, 32'd1);
      check("mis.frozen",   imem_addr,            32'h42);
    end
    redirect_valid = 1'b0;
`else
    check("mis.fault",     {31'd0, fetch_fault}, 32'd0);
    check("mis.imem_addr", imem_addr,            32'h40);
    tick();
    check("mis.id_pc0", id_pc, 32'h40);
    tick();
    check("mis.id_pc1", id_pc, 32'h44);
`endif

    // Asynchronous reset between clock edges.
    repeat (3) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.id_valid",    {31'd0, id_valid},    32'd0);
    check("arst.fetch_count", fetch_count,          32'd0);
    check("arst.imem_addr",   imem_addr,            32'h0);
    check("arst.id_instr",    id_instr,             32'h0000_0013);
    check("arst.fetch_fault", {31'd0, fetch_fault}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic checked by the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      fetch_en       = ($urandom % 8) != 0;
      id_ready       = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
`ifdef ALIGN_CHECK_EN
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc    = $urandom;
`endif
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
